senzor_apb_regs: RTL
====================

Name: senzor_apb_regs

Overview:
- Parametrised APB slave register bank for the colour-sensor front-end; next generation of the fixed 5-channel, zero-wait register map.
- Generalised to NUM_CH channels of CH_WIDTH bits, with configurable wait states and atomic snapshot capture of channel samples.
- Adds a status register with W1C sticky flags (data-ready, overrun), an interrupt output and a freeze control.
- Sits between the APB interconnect and the I2C sensor engine; drives the engine's config and seed registers and captures its samples.

Parameters:
- ADDR_WIDTH, 6: APB address width; must hold 0x10 + 4*NUM_CH.
- DATA_WIDTH, 32: APB data width; must be 32.
- NUM_CH, 5: number of sensor channels, 1..8.
- CH_WIDTH, 16: bits per channel sample, 1..DATA_WIDTH.
- WAIT_STATES, 1: extra ACCESS cycles before pready, 0..7.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- paddr  in  ADDR_WIDTH  APB address.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  DATA_WIDTH  APB write data.
- pready  out  1  transfer complete.
- prdata  out  DATA_WIDTH  read data; valid while pready is high.
- pslverr  out  1  error; valid only with pready.
- ch_data  in  NUM_CH*CH_WIDTH  packed samples; channel i at [i*CH_WIDTH +: CH_WIDTH].
- ch_valid  in  1  one-cycle pulse; a new sample set is present on ch_data.
- cfg_out  out  16  CONFIG register contents, to the sensor engine.
- seed_out  out  16  SEED register contents, to the LFSR.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, all registers 0, FSM in IDLE.
- Address map (byte addresses, word aligned):
  - 0x00 CONFIG, RW, 16 bits. Bit[7] = FREEZE; all other bits pass through unchanged to cfg_out.
  - 0x04 STATUS, RO with W1C. Bit0 DRDY, bit1 OVR.
  - 0x08 SEED, RW, 16 bits.
  - 0x0C IRQ_EN, RW. Bit0 enables DRDY interrupt, bit1 enables OVR interrupt.
  - 0x10 + 4*i CH_i, RO, zero-extended snapshot of channel i.
- APB FSM states and transitions:
  - IDLE: psel=1 and penable=0 -> SETUP.
  - SETUP -> ACCESS on the next cycle; load the wait counter with WAIT_STATES.
  - ACCESS: counter decrements each cycle. pready=1 in the cycle the counter equals 0.
  - ACCESS exit: after pready, -> SETUP if psel=1 and penable=0, otherwise -> IDLE.
  - psel dropping mid-ACCESS: abort, -> IDLE, no side effects.
- Latency: WAIT_STATES=0 gives pready in the first ACCESS cycle, i.e. a 2-cycle transfer. The latency is 2 + WAIT_STATES cycles.
- prdata: registered, loaded one cycle before pready. Outside the pready cycle it is 0.
- pslverr is asserted with pready when any of these hold:
  - paddr[1:0] != 0;
  - the address is unmapped;
  - the transfer is a write to STATUS bits other than W1C bits, or a write to any CH_i.
- An erroring transfer has no side effects.
- Writes: committed in the pready cycle. pwdata bits above register width are ignored.
- While FREEZE=1, writes to SEED are rejected: pslverr=1, SEED unchanged. CONFIG stays writable so software can unfreeze.
- Snapshot:
  - On ch_valid with FREEZE=0, all CH_i load from ch_data in the same edge (atomic); DRDY sets.
  - If DRDY is already 1 when ch_valid arrives, OVR sets as well.
  - On ch_valid with FREEZE=1, the snapshot is not updated, and OVR sets if DRDY=1.
- Simultaneous events: a W1C clear and a set event in the same cycle resolve to set wins.
- irq = |(STATUS[1:0] & IRQ_EN[1:0]), registered, so it lags the flag by 1 cycle.
- Reset during a transfer: FSM returns to IDLE; the pending write is discarded.

Optional Feature:
- Macro: SENZOR_APB_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, which wraps.
  - The counter value is captured into a TIMESTAMP register at every accepted snapshot.
  - TIMESTAMP is RO at address 0x10 + 4*NUM_CH.
- Undefined: no counter exists; that address is unmapped and returns pslverr.

Decomposition:
- Package senzor_pkg holds:
  - address offset constants (ADDR_CONFIG, ADDR_STATUS, ADDR_SEED, ADDR_IRQ_EN, ADDR_CH_BASE);
  - status bit indices and the FREEZE bit index;
  - the APB FSM state enum apb_state_t {IDLE, SETUP, ACCESS}.
- One sub-module is natural: senzor_apb_fsm, which contains the FSM plus the wait counter and outputs pready and an access strobe.
- The register bank and address decode stay in senzor_apb_regs.

Test Plan:
- Reset, then read 0x00 with WAIT_STATES=1 -> pready 3 cycles after psel, prdata=0, pslverr=0.
- Write 0x00=0x1234_5A3E, read it back -> prdata=0x0000_5A3E and cfg_out=0x5A3E.
- Pulse ch_valid with ch0=0xBEEF and ch4=0x0123, then read 0x10 and 0x20 -> 0x0000BEEF and 0x00000123; STATUS=0x1.
- Two ch_valid pulses with no clear, IRQ_EN=0x2 -> STATUS=0x3 and irq=1. Write STATUS=0x3 -> STATUS=0, irq=0 one cycle later.
- Set FREEZE, pulse ch_valid with new data -> CH_i unchanged. Then write SEED=0x00FF -> pslverr=1 and seed_out unchanged.
- Reads at 0x02 and 0x3C, and a write to 0x14 -> pslverr=1 with pready, with no register change.

Source files
------------

// File: rtl/senzor_pkg.sv
// Shared constants and types for the colour-sensor APB register bank.
// The optional timestamp register is enabled with SENZOR_APB_TIMESTAMP_EN.
package senzor_pkg;

    localparam int unsigned ADDR_CONFIG  = 32'h00;
    localparam int unsigned ADDR_STATUS  = 32'h04;
    localparam int unsigned ADDR_SEED    = 32'h08;
    localparam int unsigned ADDR_IRQ_EN  = 32'h0C;
    localparam int unsigned ADDR_CH_BASE = 32'h10;

    localparam int STATUS_DRDY    = 0;
    localparam int STATUS_OVR     = 1;
    localparam int CFG_FREEZE_BIT = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/senzor_apb_fsm.sv
// APB handshake FSM with programmable wait states; pready is registered and
// 'load' marks the cycle before pready so read data can be registered.
module senzor_apb_fsm
    import senzor_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    output logic pready,
    output logic access,
    output logic load
);

    apb_state_t state_reg;
    logic [2:0] cnt_reg;
    logic       pready_reg;

    // pready rises on the edge after 'load'; a dropped psel suppresses it
    assign load = psel && (((state_reg == SETUP) && (WAIT_STATES == 0)) ||
                           ((state_reg == ACCESS) && (cnt_reg == 3'd1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            pready_reg <= 1'b0;
        end else begin
            pready_reg <= load;
            case (state_reg)
                IDLE: begin
                    if (psel && !penable)
                        state_reg <= SETUP;
                end
                SETUP: begin
                    state_reg <= ACCESS;
                    cnt_reg   <= 3'(WAIT_STATES);
                end
                ACCESS: begin
                    if (!psel)
                        state_reg <= IDLE;
                    else if (cnt_reg == 3'd0)
                        state_reg <= (psel && !penable) ? SETUP : IDLE;
                    else
                        cnt_reg <= cnt_reg - 3'd1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pready = pready_reg;
    assign access = pready_reg && psel;

endmodule

// File: rtl/senzor_apb_regs.sv
// APB register bank for the colour-sensor front-end: config, W1C status,
// seed, irq enable and atomic channel snapshots. Optional SENZOR_APB_TIMESTAMP_EN.
module senzor_apb_regs
    import senzor_pkg::*;
#(
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_CH      = 5,
    parameter int CH_WIDTH    = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       psel,
    input  logic                       penable,
    input  logic [ADDR_WIDTH-1:0]      paddr,
    input  logic                       pwrite,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    output logic                       pready,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pslverr,
    input  logic [NUM_CH*CH_WIDTH-1:0] ch_data,
    input  logic                       ch_valid,
    output logic [15:0]                cfg_out,
    output logic [15:0]                seed_out,
    output logic                       irq
);

    localparam logic [ADDR_WIDTH-1:0] A_CONFIG = ADDR_WIDTH'(ADDR_CONFIG);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(ADDR_STATUS);
    localparam logic [ADDR_WIDTH-1:0] A_SEED   = ADDR_WIDTH'(ADDR_SEED);
    localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN = ADDR_WIDTH'(ADDR_IRQ_EN);
    localparam logic [15:0]           CFG_MASK = ~(16'h1 << CFG_FREEZE_BIT);

    logic access, load;
    logic [15:0] config_reg, seed_reg;
    logic [1:0]  status_reg, irq_en_reg, status_set, status_clr;
    logic        irq_reg, pslverr_reg;
    logic [DATA_WIDTH-1:0] prdata_reg, rd_data;
    logic [CH_WIDTH-1:0]   ch_reg [NUM_CH];
    logic [DATA_WIDTH-1:0] ch_rd  [NUM_CH];
    logic [NUM_CH-1:0]     ch_sel;
    logic cfg_sel, status_sel, seed_sel, irq_sel, ts_sel;
    logic freeze, snap, mapped, err, wr;
    logic [31:0] ts_value;

    senzor_apb_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pready  (pready),
        .access  (access),
        .load    (load)
    );

    assign freeze     = config_reg[CFG_FREEZE_BIT];
    assign snap       = ch_valid && !freeze;
    assign cfg_sel    = (paddr == A_CONFIG);
    assign status_sel = (paddr == A_STATUS);
    assign seed_sel   = (paddr == A_SEED);
    assign irq_sel    = (paddr == A_IRQ_EN);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ch_sel[gi] = (paddr == ADDR_WIDTH'(ADDR_CH_BASE + 4 * gi));
            assign ch_rd[gi]  = ch_sel[gi] ? DATA_WIDTH'(ch_reg[gi]) : '0;
            always_ff @(posedge clk) begin
                if (rst)
                    ch_reg[gi] <= '0;
                else if (snap)
                    ch_reg[gi] <= ch_data[gi*CH_WIDTH +: CH_WIDTH];
            end
        end
    endgenerate

`ifdef SENZOR_APB_TIMESTAMP_EN
    logic [31:0] ts_cnt_reg, ts_reg;
    assign ts_sel   = (paddr == ADDR_WIDTH'(ADDR_CH_BASE + 4 * NUM_CH));
    assign ts_value = ts_reg;
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt_reg <= '0;
            ts_reg     <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 32'd1;
            if (snap)
                ts_reg <= ts_cnt_reg;
        end
    end
`else
    assign ts_sel   = 1'b0;
    assign ts_value = '0;
`endif

    always_comb begin
        rd_data = '0;
        if (cfg_sel)    rd_data = DATA_WIDTH'(config_reg);
        if (status_sel) rd_data = DATA_WIDTH'(status_reg);
        if (seed_sel)   rd_data = DATA_WIDTH'(seed_reg);
        if (irq_sel)    rd_data = DATA_WIDTH'(irq_en_reg);
        if (ts_sel)     rd_data = DATA_WIDTH'(ts_value);
        for (int i = 0; i < NUM_CH; i++)
            rd_data = rd_data | ch_rd[i];
        mapped = cfg_sel || status_sel || seed_sel || irq_sel || ts_sel || (|ch_sel);
        // Read-only targets and a frozen SEED reject writes; only W1C bits may be written in STATUS
        err = !mapped || (paddr[1:0] != 2'b00) ||
              (pwrite && status_sel && (|pwdata[DATA_WIDTH-1:2])) ||
              (pwrite && ((|ch_sel) || ts_sel)) ||
              (pwrite && seed_sel && freeze);
    end

    assign wr = access && pwrite && !pslverr_reg;

    always_comb begin
        status_set              = '0;
        status_set[STATUS_DRDY] = snap;
        status_set[STATUS_OVR]  = ch_valid && status_reg[STATUS_DRDY];
        status_clr              = (wr && status_sel) ? pwdata[1:0] : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            config_reg  <= '0;
            seed_reg    <= '0;
            status_reg  <= '0;
            irq_en_reg  <= '0;
            irq_reg     <= 1'b0;
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
        end else begin
            prdata_reg  <= (load && !pwrite && !err) ? rd_data : '0;
            pslverr_reg <= load && err;
            if (wr && cfg_sel)  config_reg <= pwdata[15:0];
            if (wr && seed_sel) seed_reg   <= pwdata[15:0];
            if (wr && irq_sel)  irq_en_reg <= pwdata[1:0];
            status_reg <= (status_reg & ~status_clr) | status_set;
            irq_reg    <= |(status_reg & irq_en_reg);
        end
    end

    assign prdata   = prdata_reg;
    assign pslverr  = pslverr_reg;
    assign cfg_out  = config_reg & CFG_MASK;
    assign seed_out = seed_reg;
    assign irq      = irq_reg;

endmodule
